// File: rtl/add_acc_seq.sv
// Sums len unsigned 16-bit operands; result valid the cycle after the last accepted beat, held until out_ready.
// One operand per cycle while in ACC; flush aborts. Define ADD_ACC_SAT_EN for a saturating accumulator.
module add_acc_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [15:0]      acc;
  logic             ovf;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_q;

  logic [16:0]      add_res;
  logic             carry;
  logic [15:0]      acc_nxt;
  logic             beat;

  assign add_res = {1'b0, acc} + {1'b0, in_data};
  assign carry   = add_res[16];

`ifdef ADD_ACC_SAT_EN
  // Once a carry has been seen the accumulator is pinned at full scale.
  assign acc_nxt = (ovf | carry) ? 16'hFFFF : add_res[15:0];
`else
  assign acc_nxt = add_res[15:0];
`endif

  // flush blocks the beat in the same cycle, so in_ready drops with it.
  assign in_ready  = (state == S_ACC) && !flush;
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_sum   = out_valid ? acc : 16'h0000;
  assign out_ovf   = out_valid & ovf;
  assign beat      = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      acc   <= 16'h0000;
      ovf   <= 1'b0;
      cnt   <= '0;
      len_q <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      acc   <= 16'h0000;
      ovf   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= 16'h0000;
            ovf   <= 1'b0;
            cnt   <= '0;
            len_q <= len;
            state <= (len == '0) ? S_DONE : S_ACC;
          end
        end
        S_ACC: begin
          if (beat) begin
            acc <= acc_nxt;
            ovf <= ovf | carry;
            cnt <= cnt + CNT_ONE;
            if (cnt == len_q - CNT_ONE) begin
              state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_acc_seq.sv
// Bench for add_acc_seq: directed literal scenarios plus a randomized run, all checked against a sum-based model.
module tb_add_acc_seq;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [15:0]      in_data = 16'h0;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [15:0]      out_sum;
  logic             out_ovf;
  logic             busy;

  int n_vec = 0;
  int n_err = 0;

  // Model: phase 0 idle, 1 collecting, 2 result pending; the result is derived from the plain total.
  int     m_phase = 0;
  longint m_total = 0;
  int     m_beats = 0;
  int     m_len   = 0;

  add_acc_seq #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_sum();
`ifdef ADD_ACC_SAT_EN
    return (m_total > 65535) ? 16'hFFFF : 16'(m_total);
`else
    return 16'(m_total);
`endif
  endfunction

  function automatic logic model_ovf();
    return m_total > 65535;
  endfunction

  task automatic model_reset();
    m_phase = 0;
    m_total = 0;
    m_beats = 0;
    m_len   = 0;
  endtask

  task automatic model_step();
    if (flush) begin
      model_reset();
    end else begin
      case (m_phase)
        0: if (start) begin
          m_total = 0;
          m_beats = 0;
          m_len   = int'(len);
          m_phase = (m_len == 0) ? 2 : 1;
        end
        1: if (in_valid) begin
          m_total += longint'(in_data);
          m_beats++;
          if (m_beats == m_len) m_phase = 2;
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      chk("busy", {31'b0, busy}, {31'b0, m_phase != 0});
      chk("in_ready", {31'b0, in_ready}, {31'b0, (m_phase == 1) && !flush});
      chk("out_valid", {31'b0, out_valid}, {31'b0, m_phase == 2});
      chk("out_sum", {16'b0, out_sum}, {16'b0, (m_phase == 2) ? model_sum() : 16'h0});
      chk("out_ovf", {31'b0, out_ovf}, {31'b0, (m_phase == 2) && model_ovf()});
      @(posedge clk);
      if (rst_n) model_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int l);
    start = 1'b1;
    len   = CNT_W'(l);
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input int gap);
    logic got;
    int   t;
    in_valid = 1'b0;
    repeat (gap) step();
    in_valid = 1'b1;
    in_data  = d;
    got = 1'b0;
    t   = 0;
    while (!got && t < 20) begin
      @(negedge clk);
      got = in_ready;
      step();
      t++;
    end
    in_valid = 1'b0;
    if (!got) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: operand %0h not accepted within 20 cycles", d);
    end
  endtask

  task automatic wait_done(input logic [15:0] exp_sum, input logic exp_ovf, input int stall, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk("done_valid", {31'b0, out_valid}, 32'd1);
    chk("done_sum", {16'b0, out_sum}, {16'b0, exp_sum});
    chk("done_ovf", {31'b0, out_ovf}, {31'b0, exp_ovf});
    chk("model_sum", {16'b0, model_sum()}, {16'b0, exp_sum});
    repeat (stall) begin
      step();
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_sum", {16'b0, out_sum}, {16'b0, exp_sum});
    end
    start     = 1'b0;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_vld"}, {31'b0, out_valid}, 32'd0);
    chk({name, "_rdy"}, {31'b0, in_ready}, 32'd0);
    chk({name, "_sum"}, {16'b0, out_sum}, 32'd0);
    chk({name, "_ovf"}, {31'b0, out_ovf}, 32'd0);
    chk({name, "_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin : main
    int lat;
    rst_n = 1'b0;
    repeat (2) step();
    chk_all_zero("reset");
    rst_n = 1'b1;
    step();

    // 1+2+3 back to back
    do_start(3);
    send(16'h0001, 0);
    send(16'h0002, 0);
    send(16'h0003, 0);
    wait_done(16'h0006, 1'b0, 0, lat);
    chk("lat_3beat", lat, 0);

    // carry out of bit 15
    do_start(2);
    send(16'hFFFF, 0);
    send(16'h0002, 0);
`ifdef ADD_ACC_SAT_EN
    wait_done(16'hFFFF, 1'b1, 0, lat);
`else
    wait_done(16'h0001, 1'b1, 0, lat);
`endif

    // empty sequence
    do_start(0);
    chk("empty_rdy", {31'b0, in_ready}, 32'd0);
    wait_done(16'h0000, 1'b0, 0, lat);
    chk("lat_empty", lat, 0);

    // gaps, 5-cycle stall, start ignored while result is pending
    do_start(4);
    send(16'h1000, 2);
    send(16'h2000, 0);
    send(16'h0300, 3);
    send(16'h0040, 1);
    start = 1'b1;
    len   = CNT_W'(2);
    wait_done(16'h3340, 1'b0, 5, lat);
    step();
    chk("ignored_start_busy", {31'b0, busy}, 32'd0);

    // flush collides with a beat
    do_start(4);
    send(16'h0005, 0);
    send(16'h0006, 0);
    in_valid = 1'b1;
    in_data  = 16'h0007;
    flush    = 1'b1;
    @(negedge clk);
    chk("flush_rdy", {31'b0, in_ready}, 32'd0);
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'd0);
    do_start(1);
    send(16'h0010, 0);
    wait_done(16'h0010, 1'b0, 0, lat);

    // reset mid-accumulation
    do_start(3);
    send(16'h0004, 0);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_acc");
    step();
    rst_n = 1'b1;
    step();
    do_start(2);
    send(16'h0005, 0);
    send(16'h0007, 0);
    wait_done(16'h000C, 1'b0, 0, lat);

    // reset while the result is pending
    do_start(1);
    send(16'h0009, 0);
    chk("pre_rst_vld", {31'b0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_done");
    step();
    rst_n = 1'b1;
    step();
    do_start(1);
    send(16'h0021, 0);
    wait_done(16'h0021, 1'b0, 0, lat);

    // randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom % 4) == 0;
      len       = CNT_W'($urandom_range(0, 5));
      in_valid  = ($urandom % 2) == 0;
      in_data   = (($urandom % 2) == 0) ? 16'($urandom_range(16'hC000, 16'hFFFF)) : 16'($urandom);
      out_ready = ($urandom % 3) != 0;
      flush     = ($urandom % 50) == 0;
      rst_n     = ($urandom % 300) != 0;
      step();
    end
    rst_n     = 1'b1;
    start     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
